// File: rtl/button_debounce_array_pkg.sv
// ----------------------------------------------------------------------------
// button_debounce_array_pkg
// Shared definitions for the input-conditioning blocks:
//   - deb_state_e : debounce FSM state encoding (IDLE / COUNT). It is one-hot
//                   over two bits so that corrupted encodings are detectable.
//   - max3        : maximum of three integers.
//   - cnt_width   : bit width needed to hold the largest of three cycle counts.
// Optional feature macro used by the blocks that import this package:
//   AUTO_REPEAT_EN
// ----------------------------------------------------------------------------
package button_debounce_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_COUNT = 2'b10
  } deb_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // Counter width sized so the largest terminal count fits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_array_if.sv
// ----------------------------------------------------------------------------
// button_debounce_array_if
// Groups the raw button inputs and the conditioned outputs of the debouncer.
//   btn            : raw asynchronous button pins        (master -> slave)
//   debounce       : debounced level, 1 = pressed        (slave -> master)
//   pressed_pulse  : 1-cycle pulse on accepted press     (slave -> master)
//   released_pulse : 1-cycle pulse on accepted release   (slave -> master)
// Modports: master (pin side / consumer), slave (the debouncer).
// ----------------------------------------------------------------------------
interface button_debounce_array_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] btn;
  logic [NUM_CH-1:0] debounce;
  logic [NUM_CH-1:0] pressed_pulse;
  logic [NUM_CH-1:0] released_pulse;

  modport master (output btn, input debounce, input pressed_pulse, input released_pulse);
  modport slave  (input btn, output debounce, output pressed_pulse, output released_pulse);
endinterface

// File: rtl/button_debounce_channel.sv
// ----------------------------------------------------------------------------
// button_debounce_channel
// One debounce channel: polarity fix, 2-FF synchroniser, IDLE/COUNT filter with
// a symmetric stable-time counter, registered press/release pulses.
// Optional macro AUTO_REPEAT_EN adds a hold counter that re-fires the press
// pulse after HOLD_CYCLES and then every REPEAT_CYCLES while held.
// Ports:
//   clk            in  system clock
//   reset          in  synchronous active-high reset
//   btn            in  raw asynchronous button input
//   debounce       out debounced level (1 = pressed)
//   pressed_pulse  out 1-cycle pulse on accepted press (and auto-repeat)
//   released_pulse out 1-cycle pulse on accepted release
// ----------------------------------------------------------------------------
module button_debounce_channel
  import button_debounce_array_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic debounce,
  output logic pressed_pulse,
  output logic released_pulse
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             POLARITY = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             sync1_r;
  logic             sync2_r;
  deb_state_e       state_r;
  deb_state_e       state_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n_s;
  logic             deb_r;
  logic             deb_n_s;
  logic             press_r;
  logic             rel_r;
  logic             accept_s;
  logic             repeat_s;

  // Polarity-normalise and synchronise the raw pin into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn ^ POLARITY;
      sync2_r <= sync1_r;
    end
  end

  // FSM, counter, debounced level and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      deb_r   <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      deb_r   <= deb_n_s;
      // Pulses are registered alongside deb_r so they coincide with its edge.
      press_r <= (accept_s & sync2_r) | repeat_s;
      rel_r   <= accept_s & ~sync2_r;
    end
  end

  // Next-state logic of the stable-time filter.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    deb_n_s   = deb_r;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync2_r != deb_r) begin
          state_n_s = ST_COUNT;
          cnt_n_s   = CNT_ZERO;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (sync2_r == deb_r) begin
          // Bounce back to the accepted level: discard all progress.
          state_n_s = ST_IDLE;
          cnt_n_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = CNT_ZERO;
          deb_n_s   = sync2_r;
          accept_s  = 1'b1;
        end else begin
          cnt_n_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        // Corrupted encoding: recover to IDLE, keep the accepted level.
        state_n_s = ST_IDLE;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] hold_r;
  logic [CNT_W-1:0] hold_n_s;
  logic             rep_phase_r;
  logic             rep_phase_n_s;

  // Hold counter: first target HOLD_CYCLES, then REPEAT_CYCLES, while held.
  always_comb begin
    hold_n_s      = hold_r;
    rep_phase_n_s = rep_phase_r;
    repeat_s      = 1'b0;
    if (accept_s) begin
      // A newly accepted press or release restarts the hold timing; an
      // accepted release also suppresses any coinciding repeat pulse.
      hold_n_s      = CNT_ZERO;
      rep_phase_n_s = 1'b0;
    end else if (deb_r) begin
      if (hold_r == (rep_phase_r ? REP_LAST : HOLD_LAST)) begin
        repeat_s      = 1'b1;
        hold_n_s      = CNT_ZERO;
        rep_phase_n_s = 1'b1;
      end else begin
        hold_n_s      = hold_r + CNT_ONE;
      end
    end else begin
      hold_n_s      = CNT_ZERO;
      rep_phase_n_s = 1'b0;
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r      <= CNT_ZERO;
      rep_phase_r <= 1'b0;
    end else begin
      hold_r      <= hold_n_s;
      rep_phase_r <= rep_phase_n_s;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  assign debounce       = deb_r;
  assign pressed_pulse  = press_r;
  assign released_pulse = rel_r;

endmodule

// File: rtl/button_debounce_array.sv
// ----------------------------------------------------------------------------
// button_debounce_array
// NUM_CH independent button debouncers. Each channel is synchronised, filtered
// by a symmetric stable-time counter and edge-detected into 1-cycle pulses.
// Optional macro AUTO_REPEAT_EN enables auto-repeat press pulses while held.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   bus   slave modport of button_debounce_array_if:
//         btn (in), debounce / pressed_pulse / released_pulse (out)
// ----------------------------------------------------------------------------
module button_debounce_array
  import button_debounce_array_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input logic                    clk,
  input logic                    reset,
  button_debounce_array_if.slave bus
);

  logic [NUM_CH-1:0] deb_s;
  logic [NUM_CH-1:0] press_s;
  logic [NUM_CH-1:0] rel_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .btn            (bus.btn[i]),
      .debounce       (deb_s[i]),
      .pressed_pulse  (press_s[i]),
      .released_pulse (rel_s[i])
    );
  end

  assign bus.debounce       = deb_s;
  assign bus.pressed_pulse  = press_s;
  assign bus.released_pulse = rel_s;

endmodule
